// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// emits one bit per shift_en cycle with frame markers; consecutive words stream gaplessly.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  // The only input-to-output path: a new word may be taken in the same cycle the
  // last bit of the current word is consumed.
  assign in_ready = rst && ((r_state == IDLE) || (w_last && shift_en));
  assign w_accept = in_valid && in_ready;

  assign ser_valid   = (r_state == SHIFT);
  assign ser_out     = ser_valid && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
  assign frame_start = (r_state == SHIFT) && (r_cnt == '0);
  assign frame_last  = w_last;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shreg_nxt = in_data;
      w_cnt_nxt   = '0;
    end else if ((r_state == SHIFT) && shift_en) begin
      if (w_last) begin
        w_state_nxt = IDLE;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end else begin
        w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
        w_cnt_nxt   = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
